// File: rtl/td4x_pkg.sv
// Shared types for the TD4-class core: opcode and sequencer state encodings.
package td4x_pkg;

  localparam int OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD_A  = 4'b0000,
    OP_MOV_AB = 4'b0001,
    OP_IN_A   = 4'b0010,
    OP_MOV_AI = 4'b0011,
    OP_MOV_BA = 4'b0100,
    OP_ADD_B  = 4'b0101,
    OP_IN_B   = 4'b0110,
    OP_MOV_BI = 4'b0111,
    OP_NOP0   = 4'b1000,
    OP_OUT_B  = 4'b1001,
    OP_NOP1   = 4'b1010,
    OP_OUT_I  = 4'b1011,
    OP_JC     = 4'b1100,
    OP_HLT    = 4'b1101,
    OP_JNC    = 4'b1110,
    OP_JMP    = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_EXEC,
    ST_HALT
  } state_e;

endpackage

// File: rtl/td4x_if.sv
// Instruction-memory req/ack fetch channel between the core and the program ROM.
interface td4x_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
);
  import td4x_pkg::*;

  logic                    imem_req;
  logic [ADDR_W-1:0]       imem_addr;
  logic                    imem_ack;
  logic [OPC_W+DATA_W-1:0] imem_data;

  modport master (output imem_req, imem_addr, input imem_ack, imem_data);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_data);

endinterface

// File: rtl/td4x_exec.sv
// Combinational next-state function: applies one instruction to the architectural state.
module td4x_exec
  import td4x_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic [DATA_W-1:0]       a,
  input  logic [DATA_W-1:0]       b,
  input  logic [DATA_W-1:0]       out,
  input  logic                    cf,
  input  logic [ADDR_W-1:0]       ip,
  input  logic [OPC_W+DATA_W-1:0] ir,
  input  logic [DATA_W-1:0]       in_data,
  output logic [DATA_W-1:0]       a_nx,
  output logic [DATA_W-1:0]       b_nx,
  output logic [DATA_W-1:0]       out_nx,
  output logic                    cf_nx,
  output logic [ADDR_W-1:0]       ip_nx
);

  opcode_e           op;
  logic [DATA_W-1:0] imm;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] ip_inc;
  logic [DATA_W:0]   sum;

  assign op     = opcode_e'(ir[OPC_W+DATA_W-1 -: OPC_W]);
  assign imm    = ir[DATA_W-1:0];
  assign tgt    = imm[ADDR_W-1:0];
  assign ip_inc = ip + ADDR_W'(1);

  // Jumps test the incoming cf; every non-ADD instruction leaves cf cleared.
  always_comb begin
    sum    = '0;
    a_nx   = a;
    b_nx   = b;
    out_nx = out;
    cf_nx  = 1'b0;
    ip_nx  = ip_inc;
    case (op)
      OP_ADD_A: begin
        sum           = {1'b0, a} + {1'b0, imm};
        {cf_nx, a_nx} = sum;
      end
      OP_MOV_AB: a_nx = b;
      OP_IN_A:   a_nx = in_data;
      OP_MOV_AI: a_nx = imm;
      OP_MOV_BA: b_nx = a;
      OP_ADD_B: begin
        sum           = {1'b0, b} + {1'b0, imm};
        {cf_nx, b_nx} = sum;
      end
      OP_IN_B:   b_nx = in_data;
      OP_MOV_BI: b_nx = imm;
      OP_OUT_B:  out_nx = b;
      OP_OUT_I:  out_nx = imm;
      OP_JC:     if (cf) ip_nx = tgt;
      OP_JNC:    if (!cf) ip_nx = tgt;
      OP_JMP:    ip_nx = tgt;
      default:   ;
    endcase
  end

endmodule

// File: rtl/td4x_core.sv
// TD4-class CPU core: FETCH/EXEC/HALT sequencer, instruction register and architectural registers.
module td4x_core
  import td4x_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  td4x_if.master            imem,
  input  logic [DATA_W-1:0] in_data,
  input  logic              resume,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] ip,
  output logic              cf,
  output logic              halted,
  output logic              retire
);

  state_e                  state, state_nx;
  logic [OPC_W+DATA_W-1:0] ir;
  logic [DATA_W-1:0]       a, b;
  logic [DATA_W-1:0]       a_nx, b_nx, out_nx;
  logic                    cf_nx;
  logic [ADDR_W-1:0]       ip_nx;

  td4x_exec #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_exec (
    .a       (a),
    .b       (b),
    .out     (out_data),
    .cf      (cf),
    .ip      (ip),
    .ir      (ir),
    .in_data (in_data),
    .a_nx    (a_nx),
    .b_nx    (b_nx),
    .out_nx  (out_nx),
    .cf_nx   (cf_nx),
    .ip_nx   (ip_nx)
  );

  assign imem.imem_addr = ip;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_FETCH;
      ir       <= '0;
      a        <= '0;
      b        <= '0;
      out_data <= '0;
      cf       <= 1'b0;
      ip       <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_FETCH && imem.imem_ack) ir <= imem.imem_data;
      if (state == ST_EXEC) begin
        a        <= a_nx;
        b        <= b_nx;
        out_data <= out_nx;
        cf       <= cf_nx;
        ip       <= ip_nx;
      end
    end
  end

  always_comb begin
    state_nx      = state;
    imem.imem_req = 1'b0;
    retire        = 1'b0;
    halted        = 1'b0;
    case (state)
      ST_FETCH: begin
        imem.imem_req = !rst;
        if (imem.imem_ack) state_nx = ST_EXEC;
      end
      ST_EXEC: begin
        retire   = 1'b1;
        state_nx = (opcode_e'(ir[OPC_W+DATA_W-1 -: OPC_W]) == OP_HLT) ? ST_HALT : ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
        if (resume) state_nx = ST_FETCH;
      end
      default: state_nx = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_td4x_core.sv
// Scoreboard bench for td4x_core: two instances (4/4 and 8/6) driven by a randomized ROM model.
module tb_td4x_core;
  import td4x_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2];
  logic        ack[2];
  logic [11:0] data[2];
  logic [7:0]  din[2];
  logic        resume[2];

  logic req_w[2], ret_w[2], halt_w[2], cf_w[2];
  int   addr_w[2], ip_w[2], out_w[2];

  td4x_if #(.DATA_W(4), .ADDR_W(4)) if4 ();
  td4x_if #(.DATA_W(8), .ADDR_W(6)) if8 ();

  logic [3:0] out4, ip4;
  logic [7:0] out8;
  logic [5:0] ip8;
  logic       cf4, cf8, h4, h8, r4, r8;

  td4x_core #(.DATA_W(4), .ADDR_W(4)) u4 (
    .clk(clk), .rst(rst[0]), .imem(if4), .in_data(din[0][3:0]), .resume(resume[0]),
    .out_data(out4), .ip(ip4), .cf(cf4), .halted(h4), .retire(r4));

  td4x_core #(.DATA_W(8), .ADDR_W(6)) u8 (
    .clk(clk), .rst(rst[1]), .imem(if8), .in_data(din[1]), .resume(resume[1]),
    .out_data(out8), .ip(ip8), .cf(cf8), .halted(h8), .retire(r8));

  assign if4.imem_ack  = ack[0];
  assign if4.imem_data = data[0][7:0];
  assign if8.imem_ack  = ack[1];
  assign if8.imem_data = data[1];

  assign req_w[0] = if4.imem_req;  assign req_w[1] = if8.imem_req;
  assign addr_w[0] = 32'(if4.imem_addr); assign addr_w[1] = 32'(if8.imem_addr);
  assign ret_w[0] = r4;  assign ret_w[1] = r8;
  assign halt_w[0] = h4; assign halt_w[1] = h8;
  assign cf_w[0] = cf4;  assign cf_w[1] = cf8;
  assign ip_w[0] = 32'(ip4);   assign ip_w[1] = 32'(ip8);
  assign out_w[0] = 32'(out4); assign out_w[1] = 32'(out8);

  typedef struct {
    int ip;
    int cf;
    int out;
    int halted;
    int gap;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t cur[2];
  logic pend[2];
  int   gapc[2];
  logic first[2];

  int ma[2], mb[2], mo[2], mc[2], mi[2];

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference: architectural effect of one instruction, in plain integer arithmetic.
  function automatic exp_t model(input int k, input logic [11:0] ins, input logic [7:0] dv);
    int   dw, aw, dm, am, iv, op, imm, tgt, nip, ncf, s;
    exp_t e;
    dw  = (k != 0) ? 8 : 4;
    aw  = (k != 0) ? 6 : 4;
    dm  = (1 << dw) - 1;
    am  = (1 << aw) - 1;
    iv  = int'(ins);
    op  = (iv >> dw) & 15;
    imm = iv & dm;
    tgt = imm & am;
    nip = (mi[k] + 1) & am;
    ncf = 0;
    case (op)
      0:  begin s = ma[k] + imm; ncf = s >> dw; ma[k] = s & dm; end
      1:  ma[k] = mb[k];
      2:  ma[k] = int'(dv) & dm;
      3:  ma[k] = imm;
      4:  mb[k] = ma[k];
      5:  begin s = mb[k] + imm; ncf = s >> dw; mb[k] = s & dm; end
      6:  mb[k] = int'(dv) & dm;
      7:  mb[k] = imm;
      9:  mo[k] = mb[k];
      11: mo[k] = imm;
      12: if (mc[k] != 0) nip = tgt;
      14: if (mc[k] == 0) nip = tgt;
      15: nip = tgt;
      default: ;
    endcase
    mc[k] = ncf;
    mi[k] = nip;
    e.ip = mi[k]; e.cf = mc[k]; e.out = mo[k]; e.halted = (op == 13) ? 1 : 0; e.gap = 0;
    return e;
  endfunction

  task automatic do_reset(input int k);
    rst[k] = 1'b1; ack[k] = 1'b0; resume[k] = 1'b0;
    @(negedge clk);
    chk("req_during_rst", 32'(req_w[k]), 0);
    @(negedge clk);
    rst[k] = 1'b0;
    ma[k] = 0; mb[k] = 0; mo[k] = 0; mc[k] = 0; mi[k] = 0;
    first[k] = 1'b1;
    #1;
    chk("rst_req", 32'(req_w[k]), 1);
    chk("rst_addr", addr_w[k], 0);
    chk("rst_ip", ip_w[k], 0);
    chk("rst_cf", 32'(cf_w[k]), 0);
    chk("rst_out", out_w[k], 0);
    chk("rst_halted", 32'(halt_w[k]), 0);
    chk("rst_retire", 32'(ret_w[k]), 0);
  endtask

  // ROM model: waits for a request (resuming out of HALT if needed), inserts w wait cycles, acks.
  task automatic issue(input int k, input logic [11:0] ins, input int w, input logic [7:0] dv);
    int   t, g, r;
    exp_t e;
    t = 0;
    g = 2 + w;
    forever begin
      @(negedge clk);
      resume[k] = 1'b0;
      din[k] = 8'($urandom);
      t++;
      if (req_w[k]) break;
      if (t > 100) begin
        checks++; errors++;
        $display("FAIL fetch_timeout dut=%0d actual=no_req required=req at %0t", k, $time);
        return;
      end
      if (halt_w[k]) begin
        r = $urandom_range(0, 3);
        repeat (r) @(negedge clk);
        resume[k] = 1'b1;
        g = 3 + r + w;
      end
    end
    if (first[k]) g = -1;
    first[k] = 1'b0;
    for (int i = 0; i < w; i++) begin
      chk("wait_addr_hold", addr_w[k], mi[k]);
      resume[k] = 1'($urandom_range(0, 1));
      @(negedge clk);
      resume[k] = 1'b0;
      chk("wait_req_hold", 32'(req_w[k]), 1);
    end
    chk("fetch_addr", addr_w[k], mi[k]);
    ack[k]  = 1'b1;
    data[k] = ins;
    din[k]  = dv;
    e = model(k, ins, dv);
    e.gap = g;
    if (k == 0) q0.push_back(e); else q1.push_back(e);
    @(negedge clk);
    ack[k]    = 1'b0;
    data[k]   = 12'($urandom);
    resume[k] = 1'($urandom_range(0, 1));
  endtask

  task automatic mon(input int k);
    exp_t e;
    logic empty;
    if (rst[k]) begin
      pend[k] = 1'b0;
      gapc[k] = 0;
      return;
    end
    gapc[k]++;
    if (pend[k]) begin
      chk("ip", ip_w[k], cur[k].ip);
      chk("cf", 32'(cf_w[k]), cur[k].cf);
      chk("out_data", out_w[k], cur[k].out);
      chk("halted", 32'(halt_w[k]), cur[k].halted);
      pend[k] = 1'b0;
    end
    if (ret_w[k]) begin
      empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
      if (empty) begin
        checks++; errors++;
        $display("FAIL unexpected_retire dut=%0d actual=retire required=none at %0t", k, $time);
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        if (e.gap >= 0) chk("retire_gap", gapc[k], e.gap);
        cur[k] = e;
        pend[k] = 1'b1;
      end
      gapc[k] = 0;
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) mon(k);
  end

  task automatic run4();
    do_reset(0);
    issue(0, 12'h03E, 0, 8'h0);  // MOV A,E
    issue(0, 12'h003, 0, 8'h0);  // ADD A,3 -> A=1, CF=1
    issue(0, 12'h0E7, 0, 8'h0);  // JNC 7 falls through
    issue(0, 12'h040, 3, 8'h0);  // MOV B,A with three wait cycles
    issue(0, 12'h090, 0, 8'h0);  // OUT B -> 1
    issue(0, 12'h00F, 0, 8'h0);  // ADD A,F -> CF=1
    issue(0, 12'h0C9, 0, 8'h0);  // JC 9 taken
    issue(0, 12'h060, 0, 8'h0A); // IN B
    issue(0, 12'h090, 2, 8'h3);  // OUT B -> A
    issue(0, 12'h0B5, 0, 8'h0);  // OUT 5
    issue(0, 12'h0FF, 0, 8'h0);  // JMP F
    issue(0, 12'h0D0, 0, 8'h0);  // HLT at F -> IP wraps to 0
    issue(0, 12'h0B3, 1, 8'h0);  // OUT 3 after resume
    for (int n = 0; n < 150; n++)
      issue(0, 12'($urandom_range(0, 255)), $urandom_range(0, 3), 8'($urandom));
  endtask

  task automatic run8();
    int t;
    do_reset(1);
    issue(1, 12'h3FF, 0, 8'h0);  // MOV A,FF
    issue(1, 12'h001, 0, 8'h0);  // ADD A,1 -> A=0, CF=1
    issue(1, 12'h400, 0, 8'h0);  // MOV B,A
    issue(1, 12'h900, 1, 8'h0);  // OUT B -> 0
    issue(1, 12'hFC5, 0, 8'h0);  // JMP C5 -> IP=05
    for (int n = 0; n < 120; n++)
      issue(1, 12'($urandom), $urandom_range(0, 3), 8'($urandom));
    issue(1, 12'hBA5, 0, 8'h0);  // OUT A5
    issue(1, 12'h3FF, 0, 8'h0);  // MOV A,FF
    issue(1, 12'h002, 0, 8'h0);  // ADD A,2 -> CF=1
    t = 0;
    do begin
      @(negedge clk);
      resume[1] = 1'b0;
      t++;
      if (halt_w[1]) resume[1] = 1'b1;
    end while (!req_w[1] && t < 50);
    chk("pre_rst_req", 32'(req_w[1]), 1);
    repeat (2) @(negedge clk);
    rst[1] = 1'b1; ack[1] = 1'b1; data[1] = 12'hB5A;  // ack coinciding with rst is dropped
    @(negedge clk);
    do_reset(1);
    for (int n = 0; n < 40; n++)
      issue(1, 12'($urandom), $urandom_range(0, 2), 8'($urandom));
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; ack[k] = 1'b0; data[k] = '0; din[k] = '0; resume[k] = 1'b0;
      first[k] = 1'b1; pend[k] = 1'b0; gapc[k] = 0;
      ma[k] = 0; mb[k] = 0; mo[k] = 0; mc[k] = 0; mi[k] = 0;
    end
    fork
      run4();
      run8();
    join
    repeat (3) @(negedge clk);
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished at %0t", $time);
    $fatal(1);
  end

endmodule
